// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants, conversion FSM encoding, 7-segment table
// and digit colour palette for the VGA BCD display.
package vga_pkg;

    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 521;
    localparam int H_SYNC      = 96;
    localparam int V_SYNC      = 2;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 784;
    localparam int V_ACT_START = 31;
    localparam int V_ACT_END   = 511;

    // Ten nibbles hold the decimal form of any value up to 32 bits wide
    localparam int BCD_NIB = 10;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SHIFT  = 2'd1;
    localparam state_t CHECK  = 2'd2;
    localparam state_t COMMIT = 2'd3;

    // Segment order {a,b,c,d,e,f,g}; non-decimal nibbles stay dark
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Packed {red[2:0], green[2:0], blue[1:0]}
    function automatic logic [7:0] palette(input int unsigned idx);
        case (idx)
            0:       return 8'b111_111_11;
            1:       return 8'b111_111_00;
            2:       return 8'b000_111_11;
            3:       return 8'b000_111_00;
            default: return 8'b111_000_11;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble engine: loads bin on start, then shifts one bit per
// cycle MSB first; done marks the last shift cycle.
module bin2bcd_serial
    import vga_pkg::*;
#(
    parameter int VAL_W = 27
) (
    input  logic                 dclk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [VAL_W-1:0]     bin,
    output logic [4*BCD_NIB-1:0] bcd,
    output logic                 done
);

    logic [VAL_W-1:0]     sr;
    logic [5:0]           cnt;
    logic                 active;
    logic [4*BCD_NIB-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int unsigned n = 0; n < BCD_NIB; n++) begin
            if (bcd[4*n +: 4] >= 4'd5)
                adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            sr     <= '0;
            bcd    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            sr     <= bin;
            bcd    <= '0;
            cnt    <= 6'(VAL_W);
            active <= 1'b1;
        end else if (active) begin
            bcd <= {adj[4*BCD_NIB-2:0], sr[VAL_W-1]};
            sr  <= sr << 1;
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1)
                active <= 1'b0;
        end
    end

    assign done = active && (cnt == 6'd1);

endmodule

// File: rtl/vga_bcd_display.sv
// 640x480 VGA renderer showing a binary value as large 7-segment decimal
// digits; the value is converted once per frame during vertical blanking.
module vga_bcd_display
    import vga_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int VAL_W  = 27,
    parameter int LZB    = 1,
    parameter int X0     = 0,
    parameter int Y0     = 255,
    parameter int DIG_W  = 80,
    parameter int DIG_H  = 165,
    parameter int SEG_T  = 5
) (
    input  logic             dclk,
    input  logic             clr,
    input  logic [VAL_W-1:0] value,
    output logic             hsync,
    output logic             vsync,
    output logic [2:0]       red,
    output logic [2:0]       green,
    output logic [1:0]       blue,
    output logic             busy,
    output logic             ovf
);

    localparam int SEG_MID = (DIG_H - SEG_T) / 2;

    logic [9:0]           hc, vc;
    state_t               state;
    logic                 sample, start, conv_done;
    logic                 ovf_pend, ovf_flag;
    logic [4*BCD_NIB-1:0] bcd;
    logic [3:0]           disp [DIGITS];
    logic [7:0]           pix;
    int                   x, y, c, r;
    logic                 lead, blank;
    logic [6:0]           segs;

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == 10'(H_TOTAL - 1)) begin
            hc <= '0;
            vc <= (vc == 10'(V_TOTAL - 1)) ? '0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    assign hsync  = (hc >= 10'(H_SYNC));
    assign vsync  = (vc >= 10'(V_SYNC));
    assign sample = (hc == '0) && (vc == 10'(V_ACT_END));
    assign start  = (state == IDLE) && sample;

    bin2bcd_serial #(.VAL_W(VAL_W)) u_conv (
        .dclk  (dclk),
        .clr   (clr),
        .start (start),
        .bin   (value),
        .bcd   (bcd),
        .done  (conv_done)
    );

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            ovf_pend <= 1'b0;
            ovf_flag <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++)
                disp[i] <= '0;
        end else begin
            case (state)
                IDLE:   if (start) state <= SHIFT;
                SHIFT:  if (conv_done) state <= CHECK;
                CHECK: begin
                    ovf_pend <= |bcd[4*BCD_NIB-1:4*DIGITS];
                    state    <= COMMIT;
                end
                default: begin
                    for (int unsigned i = 0; i < DIGITS; i++)
                        disp[i] <= bcd[4*(DIGITS-1-int'(i)) +: 4];
                    ovf_flag <= ovf_pend;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // busy also covers the sample cycle so it spans the whole sample-to-commit window
    assign busy = start || (state == SHIFT) || (state == CHECK);
    assign ovf  = ovf_flag;

    always_comb begin
        pix   = '0;
        x     = int'(hc) - H_ACT_START;
        y     = int'(vc) - V_ACT_START;
        c     = 0;
        r     = 0;
        lead  = 1'b1;
        blank = 1'b0;
        segs  = '0;
        if (hc >= 10'(H_ACT_START) && hc < 10'(H_ACT_END) &&
            vc >= 10'(V_ACT_START) && vc < 10'(V_ACT_END)) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                // leading-zero run ends at the first nonzero digit; last digit always shown
                blank = (LZB != 0) && lead && (disp[i] == 4'd0) && (int'(i) != DIGITS - 1);
                if (disp[i] != 4'd0)
                    lead = 1'b0;
                segs = ovf_flag ? 7'b0000001 : (blank ? 7'b0000000 : seg_pattern(disp[i]));
                if (x >= X0 + int'(i) * DIG_W && x < X0 + (int'(i) + 1) * DIG_W &&
                    y >= Y0 && y < Y0 + DIG_H) begin
                    c = x - (X0 + int'(i) * DIG_W);
                    r = y - Y0;
                    if ((segs[6] && r < SEG_T) ||
                        (segs[5] && c >= DIG_W - SEG_T && r >= SEG_T && r < SEG_MID) ||
                        (segs[4] && c >= DIG_W - SEG_T && r >= SEG_MID + SEG_T && r < DIG_H - SEG_T) ||
                        (segs[3] && r >= DIG_H - SEG_T) ||
                        (segs[2] && c < SEG_T && r >= SEG_MID + SEG_T && r < DIG_H - SEG_T) ||
                        (segs[1] && c < SEG_T && r >= SEG_T && r < SEG_MID) ||
                        (segs[0] && r >= SEG_MID && r < SEG_MID + SEG_T))
                        pix = palette(i % 5);
                end
            end
        end
    end

    assign {red, green, blue} = pix;

endmodule

// File: tb/tb_vga_bcd_display.sv
// Self-checking bench for vga_bcd_display: counters are forced to jump to
// the sample line and to chosen pixels so each scenario stays short.
`timescale 1ns/1ps
module tb_vga_bcd_display;

    localparam int VW = 27;
    localparam int XO = 0;
    localparam int YO = 255;

    logic          dclk = 1'b0;
    logic          clr  = 1'b1;
    logic [VW-1:0] value = '0;

    logic       hs1, vs1, busy1, ovf1;
    logic [2:0] r1, g1;
    logic [1:0] b1;
    logic       hs0, vs0, busy0, ovf0;
    logic [2:0] r0, g0;
    logic [1:0] b0;

    int         n_pass = 0;
    int         n_checks = 0;
    logic [9:0] fh, fv;
    string      segtab [10];

    always #20 dclk = ~dclk;

    vga_bcd_display dut (
        .dclk(dclk), .clr(clr), .value(value), .hsync(hs1), .vsync(vs1),
        .red(r1), .green(g1), .blue(b1), .busy(busy1), .ovf(ovf1)
    );

    vga_bcd_display #(.LZB(0)) dut0 (
        .dclk(dclk), .clr(clr), .value(value), .hsync(hs0), .vsync(vs0),
        .red(r0), .green(g0), .blue(b0), .busy(busy0), .ovf(ovf0)
    );

    function automatic logic [7:0] pal_of(input int i);
        case (i % 5)
            0:       return {3'd7, 3'd7, 2'd3};
            1:       return {3'd7, 3'd7, 2'd0};
            2:       return {3'd0, 3'd7, 2'd3};
            3:       return {3'd0, 3'd7, 2'd0};
            default: return {3'd7, 3'd0, 2'd3};
        endcase
    endfunction

    // Expected colour of screen position (h, vv) for a 4-digit display of v
    function automatic logic [7:0] model(input int unsigned v, input bit lzb, input int h, input int vv);
        int          x, y, i, c;
        int unsigned p;
        byte         ch;
        string       segs;
        if (h < 144 || h >= 784 || vv < 31 || vv >= 511) return 8'h00;
        x = h - 144 - XO;
        y = vv - 31 - YO;
        if (x < 0 || y < 0 || y >= 165) return 8'h00;
        i = x / 80;
        c = x % 80;
        if (i >= 4) return 8'h00;
        p = 1;
        for (int k = 0; k < 3 - i; k++) p = p * 10;
        if (v >= 10000) segs = "g";
        else if (lzb && i < 3 && v < p) segs = "";
        else segs = segtab[(v / p) % 10];
        ch = 0;
        if (y < 5) ch = "a";
        else if (y >= 160) ch = "d";
        else if (y >= 80 && y < 85) ch = "g";
        else if (y < 80) begin
            if (c < 5) ch = "f";
            else if (c >= 75) ch = "b";
        end else begin
            if (c < 5) ch = "e";
            else if (c >= 75) ch = "c";
        end
        if (ch == 0) return 8'h00;
        for (int k = 0; k < segs.len(); k++)
            if (segs[k] == ch) return pal_of(i);
        return 8'h00;
    endfunction

    task automatic seek(input int h, input int v);
        fh = 10'(h);
        fv = 10'(v);
        force dut.hc  = fh;
        force dut.vc  = fv;
        force dut0.hc = fh;
        force dut0.vc = fv;
        #1;
    endtask

    task automatic unseek();
        release dut.hc;
        release dut.vc;
        release dut0.hc;
        release dut0.vc;
    endtask

    // Jump to the end of line 510 so the next edge is the sample cycle; bc = busy cycles seen
    task automatic convert(input int unsigned v, output int bc);
        @(negedge dclk);
        value = VW'(v);
        seek(799, 510);
        unseek();
        bc = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge dclk);
            if (busy1) bc++;
            else if (bc > 0) break;
        end
        repeat (2) @(negedge dclk);
    endtask

    task automatic test_reset();
        int cnt;
        bit seen_low;
        clr = 1'b1;
        repeat (10) @(negedge dclk);
        n_checks++; if ({hs1, vs1, hs0, vs0} !== 4'b0000) $display("FAIL reset_sync got %b want 0000", {hs1, vs1, hs0, vs0}); else n_pass++;
        n_checks++; if ({busy1, ovf1, busy0, ovf0} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {busy1, ovf1, busy0, ovf0}); else n_pass++;
        n_checks++; if ({r1, g1, b1} !== 8'h00) $display("FAIL reset_rgb got %h want 00", {r1, g1, b1}); else n_pass++;
        @(negedge dclk);
        clr = 1'b0;
        cnt = 0;
        while (cnt < 2000) begin
            @(posedge dclk); #1; cnt++;
            if (hs1) break;
        end
        n_checks++; if (cnt != 96) $display("FAIL first_hsync_rise got %0d want 96", cnt); else n_pass++;
        cnt = 0;
        seen_low = 0;
        while (cnt < 2000) begin
            @(posedge dclk); #1; cnt++;
            if (!hs1) seen_low = 1;
            if (seen_low && hs1) break;
        end
        n_checks++; if (cnt != 800) $display("FAIL line_period got %0d want 800", cnt); else n_pass++;
        n_checks++; if (vs1 !== 1'b0) $display("FAIL vsync_line1 got %b want 0", vs1); else n_pass++;
        repeat (800) @(posedge dclk);
        #1;
        n_checks++; if (vs1 !== 1'b1) $display("FAIL vsync_line2 got %b want 1", vs1); else n_pass++;
        for (int d = 0; d < 4; d++) begin
            seek(144 + XO + d * 80 + 40, 31 + YO + 2);
            n_checks++; if ({r1, g1, b1} !== model(0, 1, int'(fh), int'(fv))) $display("FAIL reset_digit_lzb d%0d got %h want %h", d, {r1, g1, b1}, model(0, 1, int'(fh), int'(fv))); else n_pass++;
            n_checks++; if ({r0, g0, b0} !== pal_of(d)) $display("FAIL reset_digit_nolzb d%0d got %h want %h", d, {r0, g0, b0}, pal_of(d)); else n_pass++;
        end
        unseek();
    endtask

    task automatic test_1234();
        int bc;
        convert(1234, bc);
        n_checks++; if (bc != 29) $display("FAIL busy_len_1234 got %0d want 29", bc); else n_pass++;
        n_checks++; if (ovf1 !== 1'b0) $display("FAIL ovf_1234 got %b want 0", ovf1); else n_pass++;
        seek(144 + XO + 160 + 2, 31 + YO + 2);
        n_checks++; if ({r1, g1, b1} !== 8'b000_111_11) $display("FAIL seg_a_of_3 got %h want 1f", {r1, g1, b1}); else n_pass++;
        for (int k = 0; k < 40; k++) begin
            seek($urandom_range(144 + XO, 144 + XO + 319), $urandom_range(31 + YO, 31 + YO + 164));
            n_checks++; if ({r1, g1, b1} !== model(1234, 1, int'(fh), int'(fv))) $display("FAIL px_1234 (%0d,%0d) got %h want %h", fh, fv, {r1, g1, b1}, model(1234, 1, int'(fh), int'(fv))); else n_pass++;
        end
        unseek();
    endtask

    task automatic test_leading_zero();
        int bc;
        convert(42, bc);
        n_checks++; if (bc != 29) $display("FAIL busy_len_42 got %0d want 29", bc); else n_pass++;
        for (int col = 0; col < 160; col += 7) begin
            for (int row = 0; row < 165; row += 11) begin
                seek(144 + XO + col, 31 + YO + row);
                n_checks++; if ({r1, g1, b1} !== 8'h00) $display("FAIL lzb_blank (%0d,%0d) got %h want 00", col, row, {r1, g1, b1}); else n_pass++;
                n_checks++; if ({r0, g0, b0} !== model(42, 0, int'(fh), int'(fv))) $display("FAIL nolzb_0042 (%0d,%0d) got %h want %h", col, row, {r0, g0, b0}, model(42, 0, int'(fh), int'(fv))); else n_pass++;
            end
        end
        seek(144 + XO + 160 + 77, 31 + YO + 40);
        n_checks++; if ({r1, g1, b1} !== 8'b000_111_11) $display("FAIL seg_b_of_4 got %h want 1f", {r1, g1, b1}); else n_pass++;
        seek(144 + XO + 160 + 40, 31 + YO + 2);
        n_checks++; if ({r1, g1, b1} !== 8'h00) $display("FAIL seg_a_of_4 got %h want 00", {r1, g1, b1}); else n_pass++;
        seek(144 + XO + 240 + 40, 31 + YO + 2);
        n_checks++; if ({r1, g1, b1} !== 8'b000_111_00) $display("FAIL seg_a_of_2 got %h want 1c", {r1, g1, b1}); else n_pass++;
        unseek();
    endtask

    task automatic test_overflow();
        int bc;
        convert(9999, bc);
        n_checks++; if (ovf1 !== 1'b0) $display("FAIL ovf_9999 got %b want 0", ovf1); else n_pass++;
        convert(10000, bc);
        n_checks++; if ({ovf1, ovf0} !== 2'b11) $display("FAIL ovf_10000 got %b want 11", {ovf1, ovf0}); else n_pass++;
        for (int d = 0; d < 4; d++) begin
            seek(144 + XO + d * 80 + 40, 31 + YO + 2);
            n_checks++; if ({r1, g1, b1} !== 8'h00) $display("FAIL ovf_row2 d%0d got %h want 00", d, {r1, g1, b1}); else n_pass++;
            seek(144 + XO + d * 80 + 40, 31 + YO + 82);
            n_checks++; if ({r1, g1, b1} !== pal_of(d)) $display("FAIL ovf_seg_g d%0d got %h want %h", d, {r1, g1, b1}, pal_of(d)); else n_pass++;
        end
        for (int k = 0; k < 30; k++) begin
            seek($urandom_range(144 + XO, 144 + XO + 319), $urandom_range(31 + YO, 31 + YO + 164));
            n_checks++; if ({r0, g0, b0} !== model(10000, 0, int'(fh), int'(fv))) $display("FAIL px_ovf (%0d,%0d) got %h want %h", fh, fv, {r0, g0, b0}, model(10000, 0, int'(fh), int'(fv))); else n_pass++;
        end
        unseek();
    endtask

    task automatic test_no_tear();
        int bc;
        convert(555, bc);
        seek(0, 100);
        unseek();
        repeat (30) @(negedge dclk);
        value = VW'(7777);
        repeat (30) @(negedge dclk);
        for (int k = 0; k < 30; k++) begin
            seek($urandom_range(144 + XO, 144 + XO + 319), $urandom_range(31 + YO, 31 + YO + 164));
            n_checks++; if ({r1, g1, b1} !== model(555, 1, int'(fh), int'(fv))) $display("FAIL no_tear (%0d,%0d) got %h want %h", fh, fv, {r1, g1, b1}, model(555, 1, int'(fh), int'(fv))); else n_pass++;
        end
        unseek();
        convert(7777, bc);
        for (int k = 0; k < 30; k++) begin
            seek($urandom_range(144 + XO, 144 + XO + 319), $urandom_range(31 + YO, 31 + YO + 164));
            n_checks++; if ({r1, g1, b1} !== model(7777, 1, int'(fh), int'(fv))) $display("FAIL after_sample (%0d,%0d) got %h want %h", fh, fv, {r1, g1, b1}, model(7777, 1, int'(fh), int'(fv))); else n_pass++;
        end
        unseek();
    endtask

    task automatic test_abort();
        int bc;
        bit seen;
        @(negedge dclk);
        value = VW'(3141);
        seek(799, 510);
        unseek();
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge dclk);
            if (busy1) begin seen = 1; break; end
        end
        n_checks++; if (!seen) $display("FAIL abort_busy_start got 0 want 1"); else n_pass++;
        repeat (10) @(negedge dclk);
        clr = 1'b1;
        #1;
        n_checks++; if ({busy1, ovf1} !== 2'b00) $display("FAIL abort_flags got %b want 00", {busy1, ovf1}); else n_pass++;
        repeat (3) @(negedge dclk);
        clr = 1'b0;
        repeat (40) @(negedge dclk);
        for (int d = 0; d < 4; d++) begin
            seek(144 + XO + d * 80 + 40, 31 + YO + 2);
            n_checks++; if ({r1, g1, b1} !== model(0, 1, int'(fh), int'(fv))) $display("FAIL abort_lzb d%0d got %h want %h", d, {r1, g1, b1}, model(0, 1, int'(fh), int'(fv))); else n_pass++;
            n_checks++; if ({r0, g0, b0} !== model(0, 0, int'(fh), int'(fv))) $display("FAIL abort_nolzb d%0d got %h want %h", d, {r0, g0, b0}, model(0, 0, int'(fh), int'(fv))); else n_pass++;
        end
        unseek();
        convert(3141, bc);
        n_checks++; if (bc != 29) $display("FAIL busy_len_3141 got %0d want 29", bc); else n_pass++;
        for (int k = 0; k < 30; k++) begin
            seek($urandom_range(144 + XO, 144 + XO + 319), $urandom_range(31 + YO, 31 + YO + 164));
            n_checks++; if ({r1, g1, b1} !== model(3141, 1, int'(fh), int'(fv))) $display("FAIL post_abort (%0d,%0d) got %h want %h", fh, fv, {r1, g1, b1}, model(3141, 1, int'(fh), int'(fv))); else n_pass++;
        end
        unseek();
    endtask

    task automatic test_random();
        int bc;
        int unsigned v;
        for (int n = 0; n < 8; n++) begin
            v = (n % 2 == 0) ? ($urandom % 12000) : ($urandom & 32'h07FF_FFFF);
            convert(v, bc);
            n_checks++; if (bc != 29) $display("FAIL busy_len_rand v=%0d got %0d want 29", v, bc); else n_pass++;
            n_checks++; if (ovf1 !== (v >= 10000)) $display("FAIL ovf_rand v=%0d got %b want %b", v, ovf1, (v >= 10000)); else n_pass++;
            for (int k = 0; k < 25; k++) begin
                seek($urandom_range(140, 799), $urandom_range(280, 520));
                n_checks++; if ({r1, g1, b1} !== model(v, 1, int'(fh), int'(fv))) $display("FAIL rand_lzb v=%0d (%0d,%0d) got %h want %h", v, fh, fv, {r1, g1, b1}, model(v, 1, int'(fh), int'(fv))); else n_pass++;
                n_checks++; if ({r0, g0, b0} !== model(v, 0, int'(fh), int'(fv))) $display("FAIL rand_nolzb v=%0d (%0d,%0d) got %h want %h", v, fh, fv, {r0, g0, b0}, model(v, 0, int'(fh), int'(fv))); else n_pass++;
            end
            unseek();
        end
    endtask

    initial begin
        segtab = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                   "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
        test_reset();
        test_1234();
        test_leading_zero();
        test_overflow();
        test_no_tear();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_bcd_display.md
VGA_BCD_DISPLAY -- requirements
Module: vga_bcd_display

Interface
REQ-001 Parameter DIGITS, default 4: number of decimal digits rendered, 1..8.
REQ-002 Parameter VAL_W, default 27: width of the binary input value, 4..32.
REQ-003 Parameter LZB, default 1: 1 blanks leading zeros, 0 shows them.
REQ-004 Parameter X0 default 0, Y0 default 255: top-left of digit 0, in active-pixel coordinates.
REQ-005 Parameter DIG_W default 80, DIG_H default 165, SEG_T default 5: digit cell width, height and stroke thickness, in pixels.
REQ-006 dclk  in  1  pixel clock, 25 MHz.
REQ-007 clr  in  1  reset, asynchronous, active-high.
REQ-008 value  in  VAL_W  unsigned binary number to display.
REQ-009 hsync, vsync  out  1 each  active-low sync outputs.
REQ-010 red  out  3, green  out  3, blue  out  2  pixel colour.
REQ-011 busy  out  1  high while a conversion is in progress.
REQ-012 ovf  out  1  high while the displayed frame holds an overflow indication.

Function
REQ-013 Timing: hc counts 0..799 and vc counts 0..520; vc advances when hc wraps 799->0; vc wraps 520->0.
REQ-014 Sync: hsync low for hc<96; vsync low for vc<2.
REQ-015 Active region: 144<=hc<784 and 31<=vc<511. RGB SHALL be 0 outside the active region and outside any lit segment.
REQ-016 Sampling: value SHALL be sampled once per frame, on the cycle hc==0 and vc==511, and never at any other time.
REQ-017 Conversion FSM states: IDLE, SHIFT, CHECK, COMMIT.
REQ-018 IDLE -> SHIFT on the sample cycle.
REQ-019 SHIFT runs serial double-dabble for exactly VAL_W cycles, one bit per cycle, MSB first. Before each shift, every BCD nibble >=5 gets +3.
REQ-020 SHIFT -> CHECK after VAL_W cycles. CHECK takes one cycle and sets an overflow flag if any BCD digit above index DIGITS-1 is nonzero, i.e. value >= 10^DIGITS.
REQ-021 CHECK -> COMMIT -> IDLE. COMMIT copies the BCD digits and the overflow flag into the display registers in a single cycle.
REQ-022 busy is high in SHIFT and CHECK. Sample-to-commit latency is VAL_W+2 cycles, which is well inside vertical blanking.
REQ-023 The display registers change only in COMMIT, so no tearing occurs within a frame.
REQ-024 Digit i (0 = most significant) occupies x in [X0+i*DIG_W, X0+(i+1)*DIG_W) and y in [Y0, Y0+DIG_H).
REQ-025 Segments a..g use 7-segment geometry with stroke SEG_T. For DIG_H=165: a at rows 0-4, b/f at rows 5-79, g at rows 80-84, c/e at rows 85-159, d at rows 160-164. Left strokes are columns 0-4; right strokes are columns DIG_W-5..DIG_W-1.
REQ-026 Segment patterns follow the standard 0-9 encoding.
REQ-027 Overflow display: every digit shows segment g only, and ovf=1.
REQ-028 With LZB=1, zeros to the left of the first nonzero digit are blank. The last digit is always shown, so value 0 displays "0".
REQ-029 Digit colour cycles through a fixed palette by index mod 5: white {7,7,3}, yellow {7,7,0}, cyan {0,7,3}, green {0,7,0}, magenta {7,0,3}.
REQ-030 Geometry that extends past the active region is clipped, never wrapped.

Reset
REQ-031 While clr=1: hc=0, vc=0, FSM=IDLE, busy=0, ovf=0, all display digits 0, overflow flag 0.
REQ-032 hsync and vsync follow the counters, so both are low during reset. RGB=0 during reset.
REQ-033 clr asserted mid-conversion aborts it with no commit. The first post-reset frame shows the reset digits: "0" with LZB=1, "0000" with LZB=0.

Structure
REQ-034 Shared package vga_pkg holds the 640x480 timing constants (800, 521, 96, 2, 144, 784, 31, 511), the FSM state typedef, the 0-9 segment encoding table and the colour palette.
REQ-035 The double-dabble engine is sub-module bin2bcd_serial, with ports dclk, clr, start, bin, bcd, done. The top level holds the counters, display registers and pixel mux.

Verification
REQ-036 Reset: hold clr 10 cycles, then release -> hc=vc=0 after reset; first hsync rise at hc=96; line period 800 cycles; frame period 416800 cycles.
REQ-037 Value 1234, DIGITS=4 -> busy high for 29 cycles after the sample at vc=511; next frame digit 2 pixel (X0+160+2, Y0+2), segment a of "3", is cyan {0,7,3}.
REQ-038 Value 42, LZB=1 -> digits 0-1 render black, digits 2-3 render "4" and "2". With LZB=0 -> "0042".
REQ-039 Value 10000, DIGITS=4 -> ovf=1; only segment g lit in all four digits; a pixel at row Y0+2 is black.
REQ-040 value changed at vc=100 -> display unchanged until the frame after the next vc=511 sample; no mid-frame change.
REQ-041 clr pulsed at the 10th SHIFT cycle -> no COMMIT occurs; display returns to the reset digits; the next sample converts normally.
